// File: rtl/fitness_collector_pkg.sv
// Shared definitions for the fitness collector: FSM encoding and accumulator width helpers.
package fitness_collector_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_START  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_WAIT   = ST_WAIT,
        S_REPORT = ST_REPORT
    } state_t;

    localparam int unsigned SCORE_WIDTH_DEF = 32;
    localparam int unsigned TRIAL_BITS_DEF  = 2;
    localparam int unsigned ACC_WIDTH       = SCORE_WIDTH_DEF + TRIAL_BITS_DEF;

    // Sum of TRIALS scores needs TRIAL_BITS of headroom above the score width.
    function automatic int unsigned acc_width(input int unsigned score_w, input int unsigned trial_b);
        return score_w + trial_b;
    endfunction

endpackage

// File: rtl/fitness_collector_best_tracker.sv
// Best-so-far record: loads on an accepted result with strictly greater fitness; clear wins.
module fitness_collector_best_tracker
    import fitness_collector_pkg::*;
#(
    parameter int unsigned ID_W  = 8,
    parameter int unsigned ACC_W = ACC_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_accept,
    input  logic             i_clear,
    input  logic [ID_W-1:0]  i_id,
    input  logic [ACC_W-1:0] i_fitness,
    output logic             o_best_valid,
    output logic [ID_W-1:0]  o_best_id,
    output logic [ACC_W-1:0] o_best_fitness
);

    logic             r_valid;
    logic [ID_W-1:0]  r_id;
    logic [ACC_W-1:0] r_fitness;
    logic             w_load;

    // Ties keep the earlier record, so only a strictly better fitness replaces it.
    assign w_load = i_accept && (!r_valid || (i_fitness > r_fitness));

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_fitness <= '0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_id      <= i_id;
            r_fitness <= i_fitness;
        end
    end

    assign o_best_valid   = r_valid;
    assign o_best_id      = r_id;
    assign o_best_fitness = r_fitness;

endmodule

// File: rtl/fitness_collector.sv
// Runs TRIALS tester passes per individual, reduces scores to sum/min, and reports over valid/ready.
module fitness_collector
    import fitness_collector_pkg::*;
#(
    parameter int unsigned TRIALS      = 4,
    parameter int unsigned TRIAL_BITS  = TRIAL_BITS_DEF,
    parameter int unsigned SCORE_WIDTH = SCORE_WIDTH_DEF,
    parameter int unsigned ID_WIDTH    = 8,
    parameter int unsigned TIMEOUT     = 67108864,
    parameter int unsigned TO_WIDTH    = 27
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 eval_req,
    input  logic [ID_WIDTH-1:0]                  eval_id,
    output logic                                 eval_busy,
    output logic                                 test_start,
    input  logic                                 test_done,
    input  logic [SCORE_WIDTH-1:0]               test_score,
    output logic                                 result_valid,
    input  logic                                 result_ready,
    output logic [ID_WIDTH-1:0]                  result_id,
    output logic [SCORE_WIDTH+TRIAL_BITS-1:0]    result_fitness,
    output logic [SCORE_WIDTH-1:0]               result_min,
    output logic                                 result_timeout,
    input  logic                                 clear_best,
    output logic                                 best_valid,
    output logic [ID_WIDTH-1:0]                  best_id,
    output logic [SCORE_WIDTH+TRIAL_BITS-1:0]    best_fitness
);

    localparam int unsigned ACC_W = acc_width(SCORE_WIDTH, TRIAL_BITS);

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_test_start;
    logic                    r_busy;
    logic                    r_result_valid;
    logic [ID_WIDTH-1:0]     r_id;
    logic [ACC_W-1:0]        r_sum;
    logic [SCORE_WIDTH-1:0]  r_min;
    logic                    r_timeout;
    logic [TRIAL_BITS-1:0]   r_trial;
    logic [TO_WIDTH-1:0]     r_to_cnt;

    logic w_done_ev;
    logic w_to_ev;
    logic w_last;
    logic w_accept;

    // Done has priority over a timeout expiring in the same cycle.
    assign w_done_ev = (r_state == S_WAIT) && test_done;
    assign w_to_ev   = (r_state == S_WAIT) && !test_done && (r_to_cnt == TO_WIDTH'(TIMEOUT - 1));
    assign w_last    = (r_trial == TRIAL_BITS'(TRIALS - 1));
    assign w_accept  = (r_state == S_REPORT) && result_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_test_start   <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_test_start   <= (w_next == S_START);
            r_busy         <= (w_next != S_IDLE);
            r_result_valid <= (w_next == S_REPORT);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (eval_req) w_next = S_START;
            S_START:  w_next = S_WAIT;
            S_WAIT:   if (w_done_ev || w_to_ev) w_next = w_last ? S_REPORT : S_START;
            S_REPORT: if (result_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Per-evaluation accumulators and the per-trial timeout counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_id      <= '0;
            r_sum     <= '0;
            r_min     <= '0;
            r_timeout <= 1'b0;
            r_trial   <= '0;
            r_to_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (eval_req) begin
                        r_id      <= eval_id;
                        r_sum     <= '0;
                        r_min     <= '1;
                        r_timeout <= 1'b0;
                        r_trial   <= '0;
                    end
                end
                S_START: r_to_cnt <= '0;
                S_WAIT: begin
                    r_to_cnt <= r_to_cnt + TO_WIDTH'(1);
                    if (w_done_ev) begin
                        r_sum <= r_sum + ACC_W'(test_score);
                        if (test_score < r_min) r_min <= test_score;
                    end else if (w_to_ev) begin
                        r_min     <= '0;
                        r_timeout <= 1'b1;
                    end
                    if ((w_done_ev || w_to_ev) && !w_last) r_trial <= r_trial + TRIAL_BITS'(1);
                end
                default: ;
            endcase
        end
    end

    fitness_collector_best_tracker #(
        .ID_W  (ID_WIDTH),
        .ACC_W (ACC_W)
    ) u_best (
        .clock          (clock),
        .reset          (reset),
        .i_accept       (w_accept),
        .i_clear        (clear_best),
        .i_id           (r_id),
        .i_fitness      (r_sum),
        .o_best_valid   (best_valid),
        .o_best_id      (best_id),
        .o_best_fitness (best_fitness)
    );

    assign eval_busy      = r_busy;
    assign test_start     = r_test_start;
    assign result_valid   = r_result_valid;
    assign result_id      = r_id;
    assign result_fitness = r_sum;
    assign result_min     = r_min;
    assign result_timeout = r_timeout;

endmodule

// File: tb/tb_fitness_collector.sv
// Scoreboard bench for fitness_collector with a behavioural tester model.
module tb_fitness_collector;

    localparam int unsigned TRIALS     = 4;
    localparam int unsigned TRIAL_BITS = 2;
    localparam int unsigned SW         = 32;
    localparam int unsigned IDW        = 8;
    localparam int unsigned TIMEOUT    = 64;
    localparam int unsigned TOW        = 7;
    localparam int unsigned AW         = SW + TRIAL_BITS;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [AW-1:0]  fit;
        logic [SW-1:0]  mn;
        logic           to;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           eval_req = 1'b0;
    logic [IDW-1:0] eval_id = '0;
    logic           eval_busy;
    logic           test_start;
    logic           test_done;
    logic [SW-1:0]  test_score;
    logic           result_valid;
    logic           result_ready = 1'b0;
    logic [IDW-1:0] result_id;
    logic [AW-1:0]  result_fitness;
    logic [SW-1:0]  result_min;
    logic           result_timeout;
    logic           clear_best = 1'b0;
    logic           best_valid;
    logic [IDW-1:0] best_id;
    logic [AW-1:0]  best_fitness;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    logic [SW-1:0] t_scores[4];
    int   t_hang  = -1;
    int   t_delay = 40;
    int   t_trial = 0;
    int   t_cur   = 0;
    int   t_cnt   = 0;
    bit   t_run   = 0;
    int   cyc     = 0;
    int   start_high = 0;
    int   start_rises = 0;
    int   done_rise_cyc = 0;
    int   valid_rise_cyc = 0;
    int   start_cyc[$];
    logic prev_start = 1'b0;
    logic prev_done = 1'b0;
    logic prev_valid = 1'b0;

    always #5 clock = ~clock;

    fitness_collector #(
        .TRIALS      (TRIALS),
        .TRIAL_BITS  (TRIAL_BITS),
        .SCORE_WIDTH (SW),
        .ID_WIDTH    (IDW),
        .TIMEOUT     (TIMEOUT),
        .TO_WIDTH    (TOW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .eval_req       (eval_req),
        .eval_id        (eval_id),
        .eval_busy      (eval_busy),
        .test_start     (test_start),
        .test_done      (test_done),
        .test_score     (test_score),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_id      (result_id),
        .result_fitness (result_fitness),
        .result_min     (result_min),
        .result_timeout (result_timeout),
        .clear_best     (clear_best),
        .best_valid     (best_valid),
        .best_id        (best_id),
        .best_fitness   (best_fitness)
    );

    // Tester model: done rises t_delay edges after the start edge; trial t_hang never finishes.
    always @(posedge clock) begin
        if (reset) begin
            t_run = 0;
            test_done  <= 1'b0;
            test_score <= '0;
        end else begin
            if (eval_req && !eval_busy) begin
                t_trial = 0;
                start_high = 0;
                start_rises = 0;
                start_cyc.delete();
            end
            if (test_start) begin
                start_high++;
                if (!prev_start) start_rises++;
                start_cyc.push_back(cyc);
                t_cur = t_trial;
                t_trial++;
                t_run = (t_cur != t_hang);
                t_cnt = t_delay;
                test_done <= 1'b0;
            end else if (t_run) begin
                t_cnt--;
                if (t_cnt == 0) begin
                    test_done  <= 1'b1;
                    test_score <= t_scores[t_cur];
                    t_run = 0;
                end
            end
        end
        if (test_done && !prev_done) done_rise_cyc = cyc;
        if (result_valid && !prev_valid) valid_rise_cyc = cyc;
        prev_start = test_start;
        prev_done  = test_done;
        prev_valid = result_valid;
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic start_eval(input logic [IDW-1:0] id, input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                              input logic [SW-1:0] s2, input logic [SW-1:0] s3, input int hang);
        exp_t e;
        logic [SW-1:0] s[4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int i = 0; i < 4; i++) t_scores[i] = s[i];
        t_hang = hang;
        e.id = id; e.fit = '0; e.mn = '1; e.to = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == hang) begin
                e.mn = '0;
                e.to = 1'b1;
            end else begin
                e.fit = e.fit + AW'(s[i]);
                if (s[i] < e.mn) e.mn = s[i];
            end
        end
        exp_q.push_back(e);
        eval_id  = id;
        eval_req = 1'b1;
        @(posedge clock); #1;
        eval_req = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!result_valid && k < 3000) begin
            @(posedge clock); #1;
            k++;
        end
        if (!result_valid) begin
            n_cmp++; n_err++;
            $display("FAIL %s_valid_wait: result_valid=%b after %0d cycles, want 1", tag, result_valid, k);
        end
    endtask

    task automatic finish_eval(input string tag, input logic clr);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s_scoreboard: result present but no expected entry", tag);
            return;
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({result_id, result_fitness, result_min, result_timeout} !== e) begin
            n_err++;
            $display("FAIL %s_result: got id=%0d fit=%h min=%h to=%b, want id=%0d fit=%h min=%h to=%b",
                     tag, result_id, result_fitness, result_min, result_timeout, e.id, e.fit, e.mn, e.to);
        end
        result_ready = 1'b1;
        clear_best   = clr;
        @(posedge clock); #1;
        result_ready = 1'b0;
        clear_best   = 1'b0;
        n_cmp++;
        if ({result_valid, eval_busy} !== 2'b00) begin
            n_err++;
            $display("FAIL %s_release: valid,busy=%b%b, want 00", tag, result_valid, eval_busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        n_cmp++;
        if ({eval_busy, test_start, result_valid, result_id, result_fitness, result_min, result_timeout,
             best_valid, best_id, best_fitness} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: busy=%b start=%b valid=%b id=%h fit=%h min=%h to=%b bv=%b bid=%h bfit=%h, want all 0",
                     eval_busy, test_start, result_valid, result_id, result_fitness, result_min,
                     result_timeout, best_valid, best_id, best_fitness);
        end
    endtask

    task automatic test_basic();
        start_eval(8'd3, 32'd10, 32'd20, 32'd5, 32'd7, -1);
        n_cmp++;
        if ({eval_busy, test_start} !== 2'b11) begin
            n_err++;
            $display("FAIL basic_req_latency: busy,start=%b%b, want 11", eval_busy, test_start);
        end
        wait_valid("basic");
        finish_eval("basic", 1'b0);
        n_cmp++;
        if (start_high != 4 || start_rises != 4) begin
            n_err++;
            $display("FAIL basic_start_pulses: high_cycles=%0d rises=%0d, want 4/4", start_high, start_rises);
        end
        n_cmp++;
        if (valid_rise_cyc != done_rise_cyc + 1) begin
            n_err++;
            $display("FAIL basic_valid_latency: valid rose cycle %0d, want %0d", valid_rise_cyc, done_rise_cyc + 1);
        end
        n_cmp++;
        if ({best_valid, best_id, best_fitness} !== {1'b1, 8'd3, 34'd42}) begin
            n_err++;
            $display("FAIL basic_best: got v=%b id=%0d fit=%0d, want v=1 id=3 fit=42", best_valid, best_id, best_fitness);
        end
    endtask

    task automatic test_best_tie();
        start_eval(8'd9, 32'd10, 32'd20, 32'd5, 32'd7, -1);
        wait_valid("tie");
        finish_eval("tie", 1'b0);
        n_cmp++;
        if ({best_valid, best_id, best_fitness} !== {1'b1, 8'd3, 34'd42}) begin
            n_err++;
            $display("FAIL tie_best: got v=%b id=%0d fit=%0d, want v=1 id=3 fit=42", best_valid, best_id, best_fitness);
        end
        start_eval(8'd4, 32'd20, 32'd10, 32'd10, 32'd10, -1);
        wait_valid("better");
        finish_eval("better", 1'b0);
        n_cmp++;
        if ({best_valid, best_id, best_fitness} !== {1'b1, 8'd4, 34'd50}) begin
            n_err++;
            $display("FAIL better_best: got v=%b id=%0d fit=%0d, want v=1 id=4 fit=50", best_valid, best_id, best_fitness);
        end
    endtask

    task automatic test_timeout();
        start_eval(8'd5, 32'd10, 32'd20, 32'd5, 32'd7, 1);
        wait_valid("timeout");
        finish_eval("timeout", 1'b0);
        n_cmp++;
        if (start_cyc.size() != 4) begin
            n_err++;
            $display("FAIL timeout_starts: got %0d starts, want 4", start_cyc.size());
        end else if (start_cyc[2] - start_cyc[1] != int'(TIMEOUT) + 1) begin
            n_err++;
            $display("FAIL timeout_abort_gap: start gap %0d cycles, want %0d", start_cyc[2] - start_cyc[1], TIMEOUT + 1);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        start_eval(8'd6, 32'd1, 32'd2, 32'd3, 32'd4, -1);
        wait_valid("hold");
        e = exp_q[0];
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if ({result_valid, result_id, result_fitness, result_min, result_timeout} !== {1'b1, e}) begin
                n_err++;
                $display("FAIL hold_stable cycle %0d: got v=%b id=%0d fit=%h min=%h to=%b, want v=1 id=%0d fit=%h min=%h to=%b",
                         i, result_valid, result_id, result_fitness, result_min, result_timeout, e.id, e.fit, e.mn, e.to);
            end
            eval_req = (i == 5);
            eval_id  = 8'hEE;
            @(posedge clock); #1;
        end
        eval_req = 1'b0;
        finish_eval("hold", 1'b0);
        repeat (10) @(posedge clock);
        #1;
        n_cmp++;
        if ({result_valid, eval_busy} !== 2'b00) begin
            n_err++;
            $display("FAIL hold_no_queue: valid,busy=%b%b, want 00", result_valid, eval_busy);
        end
    endtask

    task automatic test_clear_race();
        start_eval(8'd7, 32'd99, 32'd0, 32'd0, 32'd0, -1);
        wait_valid("clear");
        finish_eval("clear", 1'b1);
        n_cmp++;
        if ({best_valid, best_id, best_fitness} !== '0) begin
            n_err++;
            $display("FAIL clear_best: got v=%b id=%0d fit=%0d, want all 0", best_valid, best_id, best_fitness);
        end
    endtask

    task automatic test_overflow();
        start_eval(8'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        wait_valid("wide");
        finish_eval("wide", 1'b0);
        n_cmp++;
        if ({best_valid, best_id, best_fitness} !== {1'b1, 8'd8, 34'h3_FFFF_FFFC}) begin
            n_err++;
            $display("FAIL wide_best: got v=%b id=%0d fit=%h, want v=1 id=8 fit=3fffffffc", best_valid, best_id, best_fitness);
        end
    endtask

    task automatic test_reset_mid();
        start_eval(8'd10, 32'd5, 32'd5, 32'd5, 32'd5, -1);
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        n_cmp++;
        if ({eval_busy, test_start, result_valid, result_id, result_fitness, result_min, result_timeout,
             best_valid, best_id, best_fitness} !== '0) begin
            n_err++;
            $display("FAIL midreset_outputs: busy=%b start=%b valid=%b id=%h fit=%h min=%h to=%b bv=%b bid=%h bfit=%h, want all 0",
                     eval_busy, test_start, result_valid, result_id, result_fitness, result_min,
                     result_timeout, best_valid, best_id, best_fitness);
        end
        reset = 1'b0;
        void'(exp_q.pop_back());
        @(posedge clock); #1;
        start_eval(8'd11, 32'd1, 32'd1, 32'd1, 32'd1, -1);
        wait_valid("after_reset");
        finish_eval("after_reset", 1'b0);
        n_cmp++;
        if ({best_valid, best_id, best_fitness} !== {1'b1, 8'd11, 34'd4}) begin
            n_err++;
            $display("FAIL after_reset_best: got v=%b id=%0d fit=%0d, want v=1 id=11 fit=4", best_valid, best_id, best_fitness);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_best_tie();
        test_timeout();
        test_backpressure();
        test_clear_race();
        test_overflow();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expected results never produced", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
